// File: rtl/regfile_pkg.sv
// Shared types and default configuration for the multi-thread register file.
package regfile_pkg;

    localparam int unsigned NUM_TRD_DEFAULT = 8;
    localparam int unsigned NUM_REG_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned ARG_REG_DEFAULT = 1;

    localparam int unsigned TRD_W_DEFAULT = $clog2(NUM_TRD_DEFAULT);
    localparam int unsigned REG_W_DEFAULT = $clog2(NUM_REG_DEFAULT);

    typedef logic [TRD_W_DEFAULT-1:0] trd_id_t;
    typedef logic [REG_W_DEFAULT-1:0] reg_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        ARG  = 2'd2
    } spawn_state_e;

endpackage

// File: rtl/regfile_spawn_fsm.sv
// Thread-spawn sequencer: accepts a spawn request, walks the copy index
// across registers 1..NUM_REG-1, then injects the spawn argument.
// A kill of the active parent or child aborts the sequence.
module regfile_spawn_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_TRD = NUM_TRD_DEFAULT,
    parameter int unsigned NUM_REG = NUM_REG_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    localparam int unsigned TRD_W  = $clog2(NUM_TRD),
    localparam int unsigned REG_W  = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spawn_req,
    input  logic [TRD_W-1:0]   spawn_parent,
    input  logic [TRD_W-1:0]   spawn_child,
    input  logic [DATA_W-1:0]  spawn_arg,
    input  logic               kill_en,
    input  logic [TRD_W-1:0]   kill_trd,
    input  logic [NUM_TRD-1:0] trd_ready,
    output logic               spawn_rdy,
    output logic               spawn_done,
    output logic               spawn_err,
    output logic [TRD_W-1:0]   lat_parent,
    output logic [TRD_W-1:0]   lat_child,
    output logic [DATA_W-1:0]  lat_arg,
    output logic [REG_W-1:0]   cnt,
    output logic               copy_we_c,
    output logic               arg_we_c
);

    localparam logic [REG_W-1:0] CNT_LAST = REG_W'(NUM_REG - 1);

    spawn_state_e state;
    logic         kill_hit_c;
    logic         accept_c;

    // Kill aimed at the spawn in flight (thread 0 can never be killed).
    assign kill_hit_c = kill_en && (kill_trd != '0) &&
                        ((kill_trd == lat_parent) || (kill_trd == lat_child));

    // A request is legal only for a free non-zero child and a live parent.
    assign accept_c = (spawn_child != '0) && !trd_ready[spawn_child] &&
                      trd_ready[spawn_parent] &&
                      !(kill_en && (kill_trd != '0) && (kill_trd == spawn_parent));

    // Register-file write strobes derived from the current state.
    assign copy_we_c = (state == COPY) && !kill_hit_c;
    assign arg_we_c  = (state == ARG)  && !kill_hit_c;

    // Spawn sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_parent <= '0;
            lat_child  <= '0;
            lat_arg    <= '0;
            spawn_rdy  <= 1'b1;
            spawn_done <= 1'b0;
            spawn_err  <= 1'b0;
        end else begin
            spawn_done <= 1'b0;
            spawn_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        if (accept_c) begin
                            lat_parent <= spawn_parent;
                            lat_child  <= spawn_child;
                            lat_arg    <= spawn_arg;
                            cnt        <= REG_W'(1);
                            state      <= COPY;
                            spawn_rdy  <= 1'b0;
                        end else begin
                            spawn_err <= 1'b1;
                        end
                    end
                end
                COPY: begin
                    if (kill_hit_c) begin
                        state     <= IDLE;
                        spawn_rdy <= 1'b1;
                        spawn_err <= 1'b1;
                    end else begin
                        cnt <= cnt + REG_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ARG;
                        end
                    end
                end
                ARG: begin
                    state     <= IDLE;
                    spawn_rdy <= 1'b1;
                    if (kill_hit_c) begin
                        spawn_err <= 1'b1;
                    end else begin
                        spawn_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    spawn_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Multi-thread register file: NUM_TRD contexts x NUM_REG registers, two
// combinational read ports, one write port, per-thread ready tracking with
// kill, and a hardware spawn engine copying a parent context into a child.
// Optional build macro REGFILE_BANK_BYPASS_EN: reads matching a committing
// write return the write data in the same cycle.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_TRD = NUM_TRD_DEFAULT,
    parameter int unsigned NUM_REG = NUM_REG_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned ARG_REG = ARG_REG_DEFAULT,
    localparam int unsigned TRD_W  = $clog2(NUM_TRD),
    localparam int unsigned REG_W  = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TRD_W-1:0]   rd_trd,
    input  logic [REG_W-1:0]   rd_reg_a,
    input  logic [REG_W-1:0]   rd_reg_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic               rd_stall,
    input  logic               wr_en,
    input  logic [TRD_W-1:0]   wr_trd,
    input  logic [REG_W-1:0]   wr_reg,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_err,
    input  logic               spawn_req,
    input  logic [TRD_W-1:0]   spawn_parent,
    input  logic [TRD_W-1:0]   spawn_child,
    input  logic [DATA_W-1:0]  spawn_arg,
    output logic               spawn_rdy,
    output logic               spawn_done,
    output logic               spawn_err,
    input  logic               kill_en,
    input  logic [TRD_W-1:0]   kill_trd,
    output logic [NUM_TRD-1:0] trd_ready
);

    logic [DATA_W-1:0]  regs [NUM_TRD][NUM_REG];

    logic [TRD_W-1:0]   sp_parent;
    logic [TRD_W-1:0]   sp_child;
    logic [DATA_W-1:0]  sp_arg;
    logic [REG_W-1:0]   sp_cnt;
    logic               copy_we_c;
    logic               arg_we_c;

    logic               wr_commit_c;
    logic               wr_drop_c;
    logic [DATA_W-1:0]  copy_data_c;
    logic [NUM_TRD-1:0] set_mask_c;
    logic [NUM_TRD-1:0] kill_mask_c;

    regfile_spawn_fsm #(
        .NUM_TRD (NUM_TRD),
        .NUM_REG (NUM_REG),
        .DATA_W  (DATA_W)
    ) u_spawn (
        .clk          (clk),
        .rst_n        (rst_n),
        .spawn_req    (spawn_req),
        .spawn_parent (spawn_parent),
        .spawn_child  (spawn_child),
        .spawn_arg    (spawn_arg),
        .kill_en      (kill_en),
        .kill_trd     (kill_trd),
        .trd_ready    (trd_ready),
        .spawn_rdy    (spawn_rdy),
        .spawn_done   (spawn_done),
        .spawn_err    (spawn_err),
        .lat_parent   (sp_parent),
        .lat_child    (sp_child),
        .lat_arg      (sp_arg),
        .cnt          (sp_cnt),
        .copy_we_c    (copy_we_c),
        .arg_we_c     (arg_we_c)
    );

    // Pipeline writes land only in live contexts; r0 writes vanish silently.
    assign wr_commit_c = wr_en && (wr_reg != '0) && trd_ready[wr_trd];
    assign wr_drop_c   = wr_en && (wr_reg != '0) && !trd_ready[wr_trd];

    // A same-cycle pipeline write to the register being copied wins the copy.
    assign copy_data_c = (wr_commit_c && (wr_trd == sp_parent) && (wr_reg == sp_cnt))
                       ? wr_data : regs[sp_parent][sp_cnt];

    // Ready bits: spawn completion sets, kill clears (kill has priority).
    assign set_mask_c  = arg_we_c ? (NUM_TRD'(1) << sp_child) : '0;
    assign kill_mask_c = (kill_en && (kill_trd != '0)) ? (NUM_TRD'(1) << kill_trd) : '0;

    assign rd_stall = !trd_ready[rd_trd];

    // Read muxes with r0 hardwired to zero.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_reg_a != '0) begin
            rd_data_a = regs[rd_trd][rd_reg_a];
        end
        if (rd_reg_b != '0) begin
            rd_data_b = regs[rd_trd][rd_reg_b];
        end
`ifdef REGFILE_BANK_BYPASS_EN
        if (wr_commit_c && (wr_trd == rd_trd) && (wr_reg == rd_reg_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_commit_c && (wr_trd == rd_trd) && (wr_reg == rd_reg_b)) begin
            rd_data_b = wr_data;
        end
`endif
    end

    // Storage: pipeline write, spawn copy and argument injection never alias
    // because the child is not ready while the spawn is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < NUM_TRD; t++) begin
                for (int unsigned r = 0; r < NUM_REG; r++) begin
                    regs[t][r] <= '0;
                end
            end
        end else begin
            if (wr_commit_c) begin
                regs[wr_trd][wr_reg] <= wr_data;
            end
            if (copy_we_c) begin
                regs[sp_child][sp_cnt] <= copy_data_c;
            end
            if (arg_we_c) begin
                regs[sp_child][REG_W'(ARG_REG)] <= sp_arg;
            end
        end
    end

    // Per-thread ready tracking; only thread 0 is live out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trd_ready <= NUM_TRD'(1);
        end else begin
            trd_ready <= (trd_ready | set_mask_c) & ~kill_mask_c;
        end
    end

    // One-cycle flag for a write dropped because its thread was not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_drop_c;
        end
    end

endmodule
